// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with a transmit FIFO.
//
// Bytes pushed through wr_en/wr_data are queued in a FIFO_DEPTH-entry FIFO
// and sent as: start bit (0), 8 data bits LSB first, optional even-parity
// bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks. Queued frames are
// sent back to back with no idle gap between them.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the data bits)
//                      is sent between data bit 7 and the stop bit (11-bit
//                      frame). When undefined, frames are 10 bits and no
//                      parity logic is built.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   wr_en    in   push request, accepted when not full (or full with a pop)
//   wr_data  in   byte to push
//   full     out  FIFO holds FIFO_DEPTH bytes
//   empty    out  FIFO holds no bytes
//   busy     out  a frame is being sent
//   tx       out  registered serial line, idle high
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | sending the start bit
// DATA   | sending data bits 0..7
// PARITY | sending the even-parity bit (parity builds only)
// STOP   | sending the stop bit, pops the next byte at its end if any

module uart_tx #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       tx
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = 16;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;

   state_t            state_q;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]        bit_idx_q;
   logic [7:0]        shift_q;
   logic              tx_q;
`ifdef UART_TX_PARITY_EN
   logic              parity_q;
`endif

   logic       baud_done;
   logic       pop;
   logic       push;
   logic [7:0] head;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_FULL);
   assign busy      = (state_q != IDLE);
   assign tx        = tx_q;
   assign head      = mem_q[rd_ptr_q];
   assign baud_done = (baud_q == BAUD_LAST);

   // The FSM takes the head byte when leaving IDLE or at the end of a stop
   // bit. A push is allowed while full if the same edge frees an entry.
   assign pop  = !empty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));
   assign push = wr_en && (!full || pop);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               baud_q <= '0;
               tx_q   <= 1'b1;
               if (!empty) begin
                  shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^head;
`endif
                  tx_q     <= 1'b0;
                  state_q  <= START;
               end
            end

            START: begin
               if (baud_done) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  state_q   <= DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end

            DATA: begin
               if (baud_done) begin
                  baud_q <= '0;
                  if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx_q    <= parity_q;
                     state_q <= PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= STOP;
`endif
                  end else begin
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  tx_q    <= 1'b1;
                  state_q <= STOP;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
`endif

            STOP: begin
               if (baud_done) begin
                  baud_q <= '0;
                  if (!empty) begin
                     // Chain straight into the next frame's start bit.
                     shift_q  <= head;
`ifdef UART_TX_PARITY_EN
                     parity_q <= ^head;
`endif
                     tx_q     <= 1'b0;
                     state_q  <= START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end

            default: begin
               baud_q  <= '0;
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line receiver decodes frames from tx at mid-bit; the main sequence
// compares decoded bytes, framing, busy cycle counts and FIFO flags against
// hand-computed values.

module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME_CYC = FB * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic       busy;
   logic       tx;

   uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .busy    (busy),
      .tx      (tx)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Line receiver and busy monitor, sampled on the falling edge.
   logic [7:0]  rx_byte [$];
   logic        rx_par  [$];
   logic        rx_ok   [$];
   int          busy_cnt   = 0;
   int          busy_falls = 0;
   logic        busy_prev  = 1'b0;
   int          rcnt       = 0;
   bit          ractive    = 1'b0;
   logic [10:0] rbits      = '0;

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
      if (busy_prev === 1'b1 && busy === 1'b0) busy_falls++;
      busy_prev = busy;
      if (rst === 1'b1) begin
         ractive = 1'b0;
      end else if (!ractive) begin
         if (tx === 1'b0) begin
            ractive = 1'b1;
            rcnt    = 1;
            rbits   = '0;
         end
      end else begin
         if (rcnt % CPB == CPB / 2) rbits[4'(rcnt / CPB)] = tx;
         if (rcnt == FRAME_CYC - 1) begin
            ractive = 1'b0;
            rx_byte.push_back(rbits[8:1]);
            rx_par.push_back(rbits[9]);
            rx_ok.push_back(rbits[0] == 1'b0 && rbits[FB-1] == 1'b1);
         end
         rcnt++;
      end
   end

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while ((busy !== 1'b0 || empty !== 1'b1) && k < budget) begin
         tick();
         k++;
      end
      check_eq(tag, {31'd0, (busy !== 1'b0 || empty !== 1'b1)}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] v6 [6];
   logic [7:0] c6 [6];
   int r0, b0, f0;

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
      repeat (3) tick();
      check_eq("rst_tx",    tx,    1);
      check_eq("rst_busy",  busy,  0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_full",  full,  0);
      rst = 1'b0;
      tick();

      // Single frame 0x55
      r0 = rx_byte.size(); b0 = busy_cnt;
      wr_en = 1'b1; wr_data = 8'h55; tick(); wr_en = 1'b0;
      check_eq("e0_tx",    tx,    1);
      check_eq("e0_empty", empty, 0);
      tick();
      check_eq("e1_tx",    tx,    0);
      check_eq("e1_busy",  busy,  1);
      check_eq("e1_empty", empty, 1);
      repeat (3) tick();
      check_eq("start_hold", tx, 0);
      tick();
      check_eq("bit0", tx, 1);
      tick();
      check_eq("bit0_hold", tx, 1);
      wait_idle("55_idle", 200);
      check_eq("55_busy_cyc", busy_cnt - b0, FRAME_CYC);
      check_eq("55_nframes",  rx_byte.size() - r0, 1);
      check_eq("55_byte",     rx_byte[r0], 8'h55);
      check_eq("55_framing",  rx_ok[r0], 1);
`ifdef UART_TX_PARITY_EN
      check_eq("55_parity",   rx_par[r0], 0);
`endif
      check_eq("55_tx_idle",  tx, 1);

      // Two frames back to back
      r0 = rx_byte.size(); b0 = busy_cnt; f0 = busy_falls;
      wr_en = 1'b1; wr_data = 8'hA3; tick();
      wr_data = 8'h0F; tick(); wr_en = 1'b0;
      wait_idle("b2b_idle", 400);
      check_eq("b2b_busy_cyc", busy_cnt - b0, 2 * FRAME_CYC);
      check_eq("b2b_no_gap",   busy_falls - f0, 1);
      check_eq("b2b_nframes",  rx_byte.size() - r0, 2);
      check_eq("b2b_byte0",    rx_byte[r0], 8'hA3);
      check_eq("b2b_byte1",    rx_byte[r0+1], 8'h0F);
      check_eq("b2b_framing",  {31'd0, rx_ok[r0] & rx_ok[r0+1]}, 1);

      // Overfill: 6 pushes, one popped, 6th dropped
      v6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
      r0 = rx_byte.size(); b0 = busy_cnt;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = v6[i]; tick();
         if (i == 3) check_eq("ovf_full_n3", full, 0);
         if (i == 4) check_eq("ovf_full_n4", full, 1);
         if (i == 5) check_eq("ovf_full_n5", full, 1);
      end
      wr_en = 1'b0;
      wait_idle("ovf_idle", 1000);
      check_eq("ovf_nframes", rx_byte.size() - r0, 5);
      check_eq("ovf_busy_cyc", busy_cnt - b0, 5 * FRAME_CYC);
      for (int i = 0; i < 5; i++) check_eq($sformatf("ovf_byte%0d", i), rx_byte[r0+i], v6[i]);

      // Push while full on the pop edge
      c6 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      r0 = rx_byte.size();
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = c6[i]; tick();
      end
      wr_en = 1'b0;
      repeat (FRAME_CYC - 4) tick();
      check_eq("pp_pre_full", full, 1);
      check_eq("pp_pre_stop", tx,   1);
      wr_en = 1'b1; wr_data = c6[5]; tick(); wr_en = 1'b0;
      check_eq("pp_full_kept", full, 1);
      check_eq("pp_next_start", tx, 0);
      wait_idle("pp_idle", 2000);
      check_eq("pp_nframes", rx_byte.size() - r0, 6);
      for (int i = 0; i < 6; i++) check_eq($sformatf("pp_byte%0d", i), rx_byte[r0+i], c6[i]);

      // Reset mid-frame with bytes queued; push during reset ignored
      r0 = rx_byte.size();
      wr_en = 1'b1; wr_data = 8'hD0; tick();
      wr_data = 8'hD1; tick();
      wr_data = 8'hD2; tick(); wr_en = 1'b0;
      repeat (12) tick();
      check_eq("ra_busy_pre", busy, 1);
      rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; tick();
      rst = 1'b0; wr_en = 1'b0;
      check_eq("ra_tx",    tx,    1);
      check_eq("ra_busy",  busy,  0);
      check_eq("ra_empty", empty, 1);
      check_eq("ra_full",  full,  0);
      b0 = busy_cnt;
      repeat (100) tick();
      check_eq("ra_no_frames", rx_byte.size() - r0, 0);
      check_eq("ra_no_busy",   busy_cnt - b0, 0);

`ifdef UART_TX_PARITY_EN
      r0 = rx_byte.size(); b0 = busy_cnt;
      wr_en = 1'b1; wr_data = 8'h07; tick(); wr_en = 1'b0;
      wait_idle("p07_idle", 200);
      check_eq("p07_busy_cyc", busy_cnt - b0, 44);
      check_eq("p07_byte",     rx_byte[r0], 8'h07);
      check_eq("p07_parity",   rx_par[r0], 1);
      check_eq("p07_framing",  rx_ok[r0], 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
